// File: rtl/lut_perm_pkg.sv
// Shared elaboration-time helpers for the LUT pin-permutation ranking block.
// Rev 1.0: factorial/log helpers, field and rank width derivations, weight table.
`default_nettype none

package lut_perm_pkg;

  localparam int MAX_K = 8;

  function automatic int clog2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  function automatic int perm_w(input int n, input int m);
    return clog2(n + m);
  endfunction

  function automatic int enum_w(input int k);
    return clog2(fact(k));
  endfunction

  // Entry j holds j! in bits [32*j +: 32].
  function automatic logic [MAX_K*32-1:0] fact_table();
    logic [MAX_K*32-1:0] t;
    t = '0;
    for (int j = 0; j < MAX_K; j++) t[32*j +: 32] = 32'(fact(j));
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lut_perm_rank_comb.sv
// Combinational Lehmer-style rank of a packed pin permutation.
// Rev 1.0: optional legality flag under ENUMERATE_CHECK_EN.
`default_nettype none

module lut_perm_rank_comb
  import lut_perm_pkg::*;
#(
  parameter int  CLB_N  = 10,
  parameter int  CLB_M  = 6,
  parameter int  CLB_K  = 6,
  localparam int PERM_W = perm_w(CLB_N, CLB_M),
  localparam int ENUM_W = enum_w(CLB_K)
) (
  input  logic [PERM_W*CLB_K-1:0] prm,
`ifdef ENUMERATE_CHECK_EN
  output logic                    perm_err,
`endif
  output logic [ENUM_W-1:0]       enm
);

  localparam logic [MAX_K*32-1:0] W_TAB = fact_table();

  logic [PERM_W-1:0] fld [CLB_K];

  for (genvar g = 0; g < CLB_K; g++) begin : g_unpack
    assign fld[g] = prm[PERM_W*(g+1)-1 -: PERM_W];
  end

  // d_j counts lower-numbered fields smaller than field j; weight is j!.
  always_comb begin
    int d;
    enm = '0;
    for (int j = 1; j < CLB_K; j++) begin
      d = 0;
      for (int i = 0; i < j; i++) begin
        if (fld[i] < fld[j]) d = d + 1;
      end
      enm = enm + ENUM_W'(d * int'(W_TAB[32*j +: 32]));
    end
  end

`ifdef ENUMERATE_CHECK_EN
  always_comb begin
    perm_err = 1'b0;
    for (int i = 0; i < CLB_K; i++) begin
      if (int'(fld[i]) >= CLB_K) perm_err = 1'b1;
      for (int j = i + 1; j < CLB_K; j++) begin
        if (fld[i] == fld[j]) perm_err = 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/lut_perm_enumerate.sv
// Registers the lexicographic rank of a LUT pin permutation (1-cycle latency).
// Rev 1.0: optional perm_err output under ENUMERATE_CHECK_EN.
`default_nettype none

module lut_perm_enumerate
  import lut_perm_pkg::*;
#(
  parameter int  CLB_N  = 10,
  parameter int  CLB_M  = 6,
  parameter int  CLB_K  = 6,
  localparam int PERM_W = perm_w(CLB_N, CLB_M),
  localparam int ENUM_W = enum_w(CLB_K)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [PERM_W*CLB_K-1:0] prm,
`ifdef ENUMERATE_CHECK_EN
  output logic                    perm_err,
`endif
  output logic                    out_valid,
  output logic [ENUM_W-1:0]       enm
);

  logic [ENUM_W-1:0] rank;
  logic [ENUM_W-1:0] enm_d, enm_q;
  logic              out_valid_d, out_valid_q;

`ifdef ENUMERATE_CHECK_EN
  logic err;
  logic perm_err_d, perm_err_q;
`endif

  lut_perm_rank_comb #(
    .CLB_N (CLB_N),
    .CLB_M (CLB_M),
    .CLB_K (CLB_K)
  ) u_rank (
    .prm      (prm),
`ifdef ENUMERATE_CHECK_EN
    .perm_err (err),
`endif
    .enm      (rank)
  );

  // Result holds across idle cycles; only the strobe drops.
  always_comb begin
    enm_d       = in_valid ? rank : enm_q;
    out_valid_d = in_valid;
`ifdef ENUMERATE_CHECK_EN
    perm_err_d  = in_valid ? err : perm_err_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enm_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef ENUMERATE_CHECK_EN
      perm_err_q  <= 1'b0;
`endif
    end else begin
      enm_q       <= enm_d;
      out_valid_q <= out_valid_d;
`ifdef ENUMERATE_CHECK_EN
      perm_err_q  <= perm_err_d;
`endif
    end
  end

  assign enm       = enm_q;
  assign out_valid = out_valid_q;
`ifdef ENUMERATE_CHECK_EN
  assign perm_err  = perm_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_perm_enumerate.sv
// Self-checking bench for lut_perm_enumerate at default parameters (K=6, 4-bit fields).
// Rev 1.0: directed, exhaustive and randomized vectors; perm_err under ENUMERATE_CHECK_EN.
`default_nettype none

module tb_lut_perm_enumerate;
  import lut_perm_pkg::*;

  localparam int K      = 6;
  localparam int PW     = 4;
  localparam int ENUM_W = enum_w(K);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [PW*K-1:0]   prm;
  logic              out_valid;
  logic [ENUM_W-1:0] enm;
`ifdef ENUMERATE_CHECK_EN
  logic              perm_err;
`endif

  int vectors;
  int miscompares;

  lut_perm_enumerate dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .prm       (prm),
`ifdef ENUMERATE_CHECK_EN
    .perm_err  (perm_err),
`endif
    .out_valid (out_valid),
    .enm       (enm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: standard lexicographic rank, reading symbols most-significant field first.
  function automatic int ref_rank(input logic [PW*K-1:0] p);
    int s [K];
    int r, cnt, f;
    for (int pos = 0; pos < K; pos++) s[pos] = int'(p[PW*(K-1-pos) +: PW]);
    r = 0;
    for (int pos = 0; pos < K; pos++) begin
      cnt = 0;
      for (int q = pos + 1; q < K; q++) if (s[q] < s[pos]) cnt++;
      f = 1;
      for (int t = 2; t <= K - 1 - pos; t++) f = f * t;
      r = r + cnt * f;
    end
    return r;
  endfunction

  function automatic logic [PW*K-1:0] pack(input int a [K]);
    logic [PW*K-1:0] p;
    p = '0;
    for (int pos = 0; pos < K; pos++) p[PW*(K-1-pos) +: PW] = PW'(a[pos]);
    return p;
  endfunction

  // Drive at negedge, check just after the capturing posedge.
  task automatic apply(input logic [PW*K-1:0] p, input int exp, input string tag);
    @(negedge clk);
    prm      = p;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".enm"}, 32'(enm), 32'(exp));
  endtask

  initial begin
    int a [K];
    int tmp, i, j, lo, hi;
    logic [PW*K-1:0] p;
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    prm      = '0;
    #1;
    chk("reset.enm", 32'(enm), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(24'h012345, 0,   "dir0");
    apply(24'h012354, 1,   "dir1");
    apply(24'h102345, 120, "dir120");

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      prm      = 24'h543210;
      @(posedge clk);
      #1;
      chk("idle.out_valid", 32'(out_valid), 32'd0);
      chk("idle.enm_hold", 32'(enm), 32'd120);
    end

    apply(24'h543210, 719, "dir719");

    // Exhaustive sweep in lexicographic order, back-to-back.
    for (int k = 0; k < K; k++) a[k] = k;
    for (int idx = 0; idx < 720; idx++) begin
      apply(pack(a), idx, "sweep");
      i = K - 2;
      while (i >= 0 && a[i] > a[i+1]) i--;
      if (i >= 0) begin
        j = K - 1;
        while (a[j] < a[i]) j--;
        tmp = a[i]; a[i] = a[j]; a[j] = tmp;
        lo = i + 1;
        hi = K - 1;
        while (lo < hi) begin
          tmp = a[lo]; a[lo] = a[hi]; a[hi] = tmp;
          lo++;
          hi--;
        end
      end
    end

    // Randomized legal permutations against the reference model.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < K; k++) a[k] = k;
      for (int k = K - 1; k > 0; k--) begin
        j = int'($urandom_range(k, 0));
        tmp = a[k]; a[k] = a[j]; a[j] = tmp;
      end
      p = pack(a);
      apply(p, ref_rank(p), "rand");
`ifdef ENUMERATE_CHECK_EN
      chk("rand.perm_err", 32'(perm_err), 32'd0);
`endif
    end

    // Asynchronous reset between edges while a result is in flight.
    @(negedge clk);
    prm      = 24'h102345;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.enm", 32'(enm), 32'd0);
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("in_rst.enm", 32'(enm), 32'd0);
    chk("in_rst.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle.out_valid", 32'(out_valid), 32'd0);
    apply(24'h102354, ref_rank(24'h102354), "post_rst");

`ifdef ENUMERATE_CHECK_EN
    apply(24'h012344, 0, "dup");
    chk("dup.perm_err", 32'(perm_err), 32'd1);
    @(negedge clk);
    prm = 24'h012346;
    @(posedge clk);
    #1;
    chk("range.perm_err", 32'(perm_err), 32'd1);
    apply(24'h012345, 0, "legal");
    chk("legal.perm_err", 32'(perm_err), 32'd0);
`endif

    @(negedge clk);
    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
